// File: rtl/digit_scan_controller.sv
// Multiplexes packed BCD digits onto one shared digit bus and 7-segment decoder,
// with frame-aligned value updates, leading-zero blanking and a whole-display blink.
module digit_scan_controller #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_digits,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [3:0]              digit_value,
    output logic                    digit_blank,
    output logic                    frame_done
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_DARK,
        ST_SCAN
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DW-1:0]           active_q, active_d;
    logic [DW-1:0]           pending_q, pending_d;
    logic                    pending_full_q, pending_full_d;
    logic [FRM_W-1:0]        frm_cnt_q, frm_cnt_d;
    logic                    phase_q, phase_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]              value_q, value_d;
    logic                    blank_q, blank_d;
    logic                    frame_done_q, frame_done_d;

    logic                    accept;
    logic                    div_tc;
    logic                    idx_last;
    logic                    boundary;
    logic [3:0]              digits [NUM_DIGITS];
    logic [3:0]              cur;
    logic                    upper_zero;
    logic                    lz_hit;
    logic [NUM_DIGITS-1:0]   onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_DARK;
            div_q          <= '0;
            idx_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            frm_cnt_q      <= '0;
            phase_q        <= 1'b0;
            sel_q          <= '0;
            value_q        <= 4'd0;
            blank_q        <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            idx_q          <= idx_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frm_cnt_q      <= frm_cnt_d;
            phase_q        <= phase_d;
            sel_q          <= sel_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        accept   = load_valid & ~pending_full_q;
        div_tc   = (div_q == DIV_W'(REFRESH_DIV - 1));
        idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
        boundary = (state_q == ST_SCAN) & div_tc & idx_last;

        state_d        = state_q;
        div_d          = div_q;
        idx_d          = idx_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;

        case (state_q)
            ST_DARK: begin
                if (accept) begin
                    active_d = load_digits;
                    state_d  = ST_SCAN;
                    div_d    = '0;
                    idx_d    = '0;
                end
            end
            ST_SCAN: begin
                div_d = div_tc ? '0 : div_q + DIV_W'(1);
                if (div_tc) begin
                    idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
                end
                // Accept requires an empty pending slot, so transfer and refill never collide.
                if (boundary && pending_full_q) begin
                    active_d       = pending_q;
                    pending_full_d = 1'b0;
                end
                if (accept) begin
                    pending_d      = load_digits;
                    pending_full_d = 1'b1;
                end
            end
            default: state_d = ST_DARK;
        endcase
    end

    always_comb begin
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        if (!blink_en) begin
            frm_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (boundary) begin
            if (frm_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = active_q[4*i +: 4];
        end
        cur = digits[idx_q];

        // A digit is a leading zero when it and every more significant digit are zero.
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= idx_q) && (digits[j] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        lz_hit = blank_lz & (idx_q != '0) & upper_zero;

        onehot        = '0;
        onehot[idx_q] = 1'b1;

        sel_d        = onehot;
        value_d      = cur;
        blank_d      = 1'b0;
        frame_done_d = boundary;

        if ((state_q == ST_DARK) || (blink_en & phase_q) || lz_hit) begin
            sel_d   = '0;
            blank_d = 1'b1;
        end else if (cur > 4'd9) begin
            blank_d = 1'b1;
        end
    end

    assign load_ready  = ~pending_full_q;
    assign digit_sel   = sel_q;
    assign digit_value = value_q;
    assign digit_blank = blank_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller with a 2-digit, 4-cycle-slot, 2-frame-blink build.
module tb_digit_scan_controller;

    localparam int ND = 2;
    localparam int RD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [7:0]    load_digits;
    logic          blank_lz;
    logic          blink_en;
    logic [1:0]    digit_sel;
    logic [3:0]    digit_value;
    logic          digit_blank;
    logic          frame_done;

    int            total = 0;
    int            bad   = 0;
    int            k     = 0;
    logic [7:0]    disp;

    digit_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_digits(load_digits),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .digit_sel  (digit_sel),
        .digit_value(digit_value),
        .digit_blank(digit_blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // k counts clock edges since the first accept; each digit slot is 4 edges, a frame 8.
    task automatic step(input logic dark);
        int         slot;
        logic [3:0] dg;
        logic [1:0] esel;
        logic       eblank;
        @(posedge clk);
        @(negedge clk);
        k++;
        slot   = ((k - 1) % 8) / 4;
        dg     = (slot == 1) ? disp[7:4] : disp[3:0];
        esel   = (slot == 1) ? 2'b10 : 2'b01;
        eblank = 1'b0;
        if (dark || (blank_lz && (slot == 1) && (disp[7:4] == 4'd0))) begin
            esel   = 2'b00;
            eblank = 1'b1;
        end else if (dg > 4'd9) begin
            eblank = 1'b1;
        end
        chk("sel", 32'(digit_sel), 32'(esel));
        chk("blank", 32'(digit_blank), 32'(eblank));
        if (!eblank) chk("value", 32'(digit_value), 32'(dg));
        chk("frame_done", 32'(frame_done), 32'((k % 8) == 0));
    endtask

    task automatic dark_check(input string tag);
        chk({tag, "_sel"}, 32'(digit_sel), 32'(0));
        chk({tag, "_blank"}, 32'(digit_blank), 32'(1));
        chk({tag, "_value"}, 32'(digit_value), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
        chk({tag, "_ready"}, 32'(load_ready), 32'(1));
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_digits = 8'h00;
        blank_lz    = 1'b0;
        blink_en    = 1'b0;
        disp        = 8'h00;

        // Reset and idle in DARK
        repeat (2) @(negedge clk);
        dark_check("reset");
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            dark_check("idle");
        end

        // First load goes straight to the display
        chk("ready_dark", 32'(load_ready), 32'(1));
        load_valid  = 1'b1;
        load_digits = 8'h17;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        chk("sel_at_accept", 32'(digit_sel), 32'(0));
        chk("ready_after_dark_accept", 32'(load_ready), 32'(1));
        load_valid = 1'b0;
        disp       = 8'h17;
        repeat (16) step(1'b0);

        // Mid-frame load held pending until the boundary; 0x99 offered while busy
        repeat (2) step(1'b0);
        load_valid  = 1'b1;
        load_digits = 8'h42;
        step(1'b0);
        chk("ready_pending", 32'(load_ready), 32'(0));
        load_digits = 8'h99;
        repeat (4) begin
            step(1'b0);
            chk("ready_held", 32'(load_ready), 32'(0));
        end
        load_valid = 1'b0;
        step(1'b0);
        chk("ready_after_xfer", 32'(load_ready), 32'(1));
        disp = 8'h42;
        repeat (16) step(1'b0);

        // Leading-zero blanking
        blank_lz    = 1'b1;
        load_valid  = 1'b1;
        load_digits = 8'h05;
        step(1'b0);
        load_valid = 1'b0;
        repeat (7) step(1'b0);
        disp = 8'h05;
        repeat (8) step(1'b0);
        blank_lz = 1'b0;
        repeat (8) step(1'b0);
        blank_lz    = 1'b1;
        load_valid  = 1'b1;
        load_digits = 8'h00;
        step(1'b0);
        load_valid = 1'b0;
        repeat (7) step(1'b0);
        disp = 8'h00;
        repeat (8) step(1'b0);

        // Invalid BCD digit
        blank_lz    = 1'b0;
        load_valid  = 1'b1;
        load_digits = 8'h3C;
        step(1'b0);
        load_valid = 1'b0;
        repeat (7) step(1'b0);
        disp = 8'h3C;
        repeat (8) step(1'b0);

        // Blink: two frames lit, two dark
        load_valid  = 1'b1;
        load_digits = 8'h17;
        step(1'b0);
        load_valid = 1'b0;
        repeat (7) step(1'b0);
        disp     = 8'h17;
        repeat (8) step(1'b0);
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            repeat (8) step(((f / 2) % 2) == 1);
        end
        repeat (2) step(1'b1);
        blink_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        k++;
        repeat (5) step(1'b0);

        // Reset mid-scan with a value pending
        load_valid  = 1'b1;
        load_digits = 8'h88;
        step(1'b0);
        load_valid = 1'b0;
        chk("ready_before_reset", 32'(load_ready), 32'(0));
        step(1'b0);
        #2;
        reset = 1'b1;
        #1;
        dark_check("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            dark_check("post_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
